// File: rtl/usb_in_packer_if.sv
// Stream-side and IN-endpoint-buffer-side signals of usb_in_packer.
// The slave modport is the packer; the master modport is whatever drives it.
interface usb_in_packer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack;
  logic       busy;
  logic [15:0] pkt_count;

  modport master (
    output in_data, in_valid, flush, buf_in_ready, buf_in_commit_ack,
    input  in_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len, busy, pkt_count
  );

  modport slave (
    input  in_data, in_valid, flush, buf_in_ready, buf_in_commit_ack,
    output in_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len, busy, pkt_count
  );
endinterface

// File: rtl/usb_in_packer.sv
// Packs a byte stream into USB IN-endpoint packets, committing on full packet,
// flush or idle timeout through the buf_in_ready / commit / ack handshake.
module usb_in_packer #(
  parameter int MAX_LEN = 512,
  parameter int TIMEOUT = 50000
) (
  input logic             clk_50,
  input logic             reset,
  usb_in_packer_if.slave  io
);
  // state       | meaning
  // ST_IDLE     | waiting for the IN buffer to be free (ready_s)
  // ST_FILL     | accepting bytes into the buffer
  // ST_COMMIT   | commit request raised, waiting for ack_s
  // ST_WAIT_ACK | waiting for ack_s to return low
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  localparam logic [9:0]  MAX_LEN_C  = 10'(MAX_LEN);
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [1:0]  ready_sync_q, ack_sync_q;
  logic        ready_s, ack_s;
  logic [9:0]  count_q;
  logic        commit_pend_q;
  logic [15:0] timer_q;
  logic [8:0]  addr_q;
  logic [7:0]  data_q;
  logic        wren_q;
  logic [9:0]  len_q;
  logic [15:0] pkt_count_q;

  logic in_ready_c, commit_c, busy_c;
  logic accept, count_nz, idle_tick, timer_hit, set_pend, commit_now;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      ready_sync_q <= '0;
      ack_sync_q   <= '0;
    end else begin
      ready_sync_q <= {ready_sync_q[0], io.buf_in_ready};
      ack_sync_q   <= {ack_sync_q[0], io.buf_in_commit_ack};
    end
  end

  assign ready_s = ready_sync_q[1];
  assign ack_s   = ack_sync_q[1];

  assign accept    = in_ready_c && io.in_valid;
  assign count_nz  = (count_q != 10'd0);
  assign idle_tick = (state_q == ST_FILL) && count_nz && !accept;
  // Firing one count early makes the commit land exactly TIMEOUT edges after the last byte.
  assign timer_hit = TIMEOUT_EN && idle_tick && (timer_q >= TIMEOUT_C - 16'd1);
  assign set_pend  = accept && ((count_q + 10'd1 == MAX_LEN_C) || io.flush);
  // With no byte in flight the commit can be raised on the very next edge.
  assign commit_now = idle_tick && !commit_pend_q && (io.flush || timer_hit);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ready_s) state_d = ST_FILL;
      ST_FILL:     if (commit_pend_q || commit_now) state_d = ST_COMMIT;
      ST_COMMIT:   if (ack_s) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (!ack_s) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    commit_c   = 1'b0;
    busy_c     = 1'b1;
    case (state_q)
      ST_IDLE:   busy_c     = 1'b0;
      ST_FILL:   in_ready_c = (count_q < MAX_LEN_C) && !commit_pend_q;
      ST_COMMIT: commit_c   = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      commit_pend_q <= 1'b0;
      timer_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wren_q        <= 1'b0;
      len_q         <= '0;
      pkt_count_q   <= '0;
    end else begin
      wren_q <= accept;
      if (accept) begin
        addr_q <= count_q[8:0];
        data_q <= io.in_data;
      end

      if (state_q != ST_FILL) count_q <= '0;
      else if (accept)        count_q <= count_q + 10'd1;

      if (state_q != ST_FILL || commit_pend_q) commit_pend_q <= 1'b0;
      else if (set_pend)                       commit_pend_q <= 1'b1;

      if (state_q != ST_FILL || accept)
        timer_q <= '0;
      else if (TIMEOUT_EN && idle_tick && timer_q != TIMEOUT_C)
        timer_q <= timer_q + 16'd1;

      if (state_q == ST_FILL && state_d == ST_COMMIT) len_q <= count_q;

      if (state_q == ST_COMMIT && ack_s) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign io.in_ready          = in_ready_c;
  assign io.buf_in_addr       = addr_q;
  assign io.buf_in_data       = data_q;
  assign io.buf_in_wren       = wren_q;
  assign io.buf_in_commit     = commit_c;
  assign io.buf_in_commit_len = len_q;
  assign io.busy              = busy_c;
  assign io.pkt_count         = pkt_count_q;
endmodule

// File: tb/tb_usb_in_packer.sv
// Self-checking bench for usb_in_packer: directed scenarios plus a randomized
// stream checked against a packet-level model built from queues.
module tb_usb_in_packer;
  localparam int MAX_LEN = 512;
  localparam int TIMEOUT = 100;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b1;
  int          tests  = 0;
  int          fails  = 0;
  int          order_err = 0;
  logic [15:0] pkts_model = '0;
  logic [8:0]  wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  exp_q[$];

  usb_in_packer_if bus ();

  usb_in_packer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .io     (bus)
  );

  always #5 clk_50 = ~clk_50;

  // Buffer-side monitor: records every write and flags a commit overlapping a write.
  always @(negedge clk_50) begin
    if (!reset && bus.buf_in_wren === 1'b1) begin
      wr_addr.push_back(bus.buf_in_addr);
      wr_data.push_back(bus.buf_in_data);
    end
    if (!reset && bus.buf_in_commit === 1'b1 && bus.buf_in_wren === 1'b1) order_err++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.flush    = f;
    exp_q.push_back(d);
    tick();
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_seq(output logic dropped, output logic [15:0] cnt, output logic idle);
    int n;
    bus.buf_in_ready      = 1'b0;
    bus.buf_in_commit_ack = 1'b1;
    n = 0;
    while (bus.buf_in_commit === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    dropped = (bus.buf_in_commit === 1'b0);
    cnt     = bus.pkt_count;
    repeat (2) tick();
    bus.buf_in_commit_ack = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    idle = (bus.busy === 1'b0);
  endtask

  function automatic int write_errs();
    int e = 0;
    if (wr_addr.size() != exp_q.size()) e++;
    for (int i = 0; i < wr_addr.size() && i < exp_q.size(); i++)
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.buf_in_ready      = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    repeat (3) tick();
    tests++;
    if ({bus.in_ready, bus.buf_in_wren, bus.buf_in_commit, bus.busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready/wren/commit/busy=%b required 0000",
               {bus.in_ready, bus.buf_in_wren, bus.buf_in_commit, bus.busy});
    end
    tests++;
    if ({bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit_len, bus.pkt_count} !== 43'b0) begin
      fails++;
      $display("FAIL reset_data: addr=%0h data=%0h len=%0d cnt=%0d required all 0",
               bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit_len, bus.pkt_count);
    end
    reset = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy: busy=%b required 0 with buffer not ready", bus.busy);
    end
  endtask

  task automatic test_empty_flush();
    int bad, n;
    logic [15:0] cnt0;
    cnt0 = bus.pkt_count;
    clear_mon();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      bus.flush = 1'b1;
      tick();
      if (bus.busy !== 1'b0 || bus.buf_in_commit !== 1'b0) bad++;
      bus.flush = 1'b0;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL empty_flush_idle: %0d cycles left idle, required 0", bad);
    end
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL empty_flush_fill: in_ready=%b required 1", bus.in_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.flush = 1'b1;
      tick();
      if (bus.buf_in_commit !== 1'b0 || bus.in_ready !== 1'b1) bad++;
      bus.flush = 1'b0;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL empty_flush_count0: %0d bad cycles, required 0", bad);
    end
    tests++;
    if (wr_addr.size() != 0 || bus.pkt_count !== cnt0) begin
      fails++;
      $display("FAIL empty_flush_effects: writes=%0d cnt=%0d required 0 and %0d",
               wr_addr.size(), bus.pkt_count, cnt0);
    end
  endtask

  task automatic test_single_flush();
    int n;
    logic dropped, idle;
    logic [15:0] cnt;
    clear_mon();
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    send_byte(8'h05, 1'b1);
    idle_inputs();
    tests++;
    if ({bus.buf_in_wren, bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit} !== {1'b1, 9'd0, 8'h05, 1'b0}) begin
      fails++;
      $display("FAIL single_write: wren=%b addr=%0d data=%0h commit=%b required 1 0 05 0",
               bus.buf_in_wren, bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit);
    end
    tick();
    tests++;
    if ({bus.buf_in_commit, bus.buf_in_commit_len} !== {1'b1, 10'd1}) begin
      fails++;
      $display("FAIL single_commit: commit=%b len=%0d required 1 1", bus.buf_in_commit, bus.buf_in_commit_len);
    end
    ack_seq(dropped, cnt, idle);
    pkts_model++;
    tests++;
    if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1) begin
      fails++;
      $display("FAIL single_ack: dropped=%b cnt=%0d idle=%b required 1 %0d 1", dropped, cnt, idle, pkts_model);
    end
  endtask

  task automatic test_flush_alone();
    int n;
    logic dropped, idle;
    logic [15:0] cnt;
    clear_mon();
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    idle_inputs();
    tests++;
    if (bus.buf_in_commit !== 1'b0) begin
      fails++;
      $display("FAIL flush_alone_early: commit=%b required 0 before flush", bus.buf_in_commit);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tests++;
    if ({bus.buf_in_commit, bus.buf_in_commit_len} !== {1'b1, 10'd2} || write_errs() != 0) begin
      fails++;
      $display("FAIL flush_alone_commit: commit=%b len=%0d write_errs=%0d required 1 2 0",
               bus.buf_in_commit, bus.buf_in_commit_len, write_errs());
    end
    ack_seq(dropped, cnt, idle);
    pkts_model++;
    tests++;
    if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1) begin
      fails++;
      $display("FAIL flush_alone_ack: dropped=%b cnt=%0d idle=%b required 1 %0d 1", dropped, cnt, idle, pkts_model);
    end
  endtask

  task automatic test_full_packet();
    int n, ready_err, bad;
    logic dropped, idle;
    logic [15:0] cnt;
    clear_mon();
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    ready_err = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bus.in_ready !== 1'b1) ready_err++;
      send_byte(i[7:0], 1'b0);
    end
    idle_inputs();
    tests++;
    if (ready_err != 0) begin
      fails++;
      $display("FAIL full_throughput: in_ready low on %0d byte cycles, required 0", ready_err);
    end
    tests++;
    if (bus.in_ready !== 1'b0 || bus.buf_in_commit !== 1'b0) begin
      fails++;
      $display("FAIL full_block: in_ready=%b commit=%b required 0 0", bus.in_ready, bus.buf_in_commit);
    end
    tick();
    tests++;
    if ({bus.buf_in_commit, bus.buf_in_commit_len} !== {1'b1, 10'd512}) begin
      fails++;
      $display("FAIL full_commit: commit=%b len=%0d required 1 512", bus.buf_in_commit, bus.buf_in_commit_len);
    end
    tests++;
    if (write_errs() != 0) begin
      fails++;
      $display("FAIL full_writes: %0d address/data errors over %0d writes, required 0", write_errs(), wr_addr.size());
    end
    ack_seq(dropped, cnt, idle);
    pkts_model++;
    tests++;
    if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1) begin
      fails++;
      $display("FAIL full_ack: dropped=%b cnt=%0d idle=%b required 1 %0d 1", dropped, cnt, idle, pkts_model);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.in_ready !== 1'b0) bad++;
    end
    bus.buf_in_ready = 1'b1;
    wait_ready(6, n);
    tests++;
    if (bad != 0 || bus.in_ready !== 1'b1 || n < 2 || n > 4) begin
      fails++;
      $display("FAIL full_rearm: early_ready=%0d in_ready=%b after %0d cycles, required 0 1 within 2..4", bad, bus.in_ready, n);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic dropped, idle;
    logic [15:0] cnt;
    clear_mon();
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    idle_inputs();
    n = 0;
    while (bus.buf_in_commit !== 1'b1 && n < 130) begin
      tick();
      n++;
    end
    tests++;
    if (bus.buf_in_commit !== 1'b1 || n < TIMEOUT - 1 || n > TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_delay: commit=%b after %0d idle cycles, required 1 after %0d +-1", bus.buf_in_commit, n, TIMEOUT);
    end
    tests++;
    if (bus.buf_in_commit_len !== 10'd3 || write_errs() != 0) begin
      fails++;
      $display("FAIL timeout_len: len=%0d write_errs=%0d required 3 0", bus.buf_in_commit_len, write_errs());
    end
    ack_seq(dropped, cnt, idle);
    pkts_model++;
    tests++;
    if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1) begin
      fails++;
      $display("FAIL timeout_ack: dropped=%b cnt=%0d idle=%b required 1 %0d 1", dropped, cnt, idle, pkts_model);
    end
  endtask

  task automatic test_backpressure();
    int n, bad;
    clear_mon();
    bus.buf_in_ready = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'h3C;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL bp_blocked: in_ready high %0d cycles, writes=%0d, required 0 0", bad, wr_addr.size());
    end
    bus.buf_in_ready = 1'b1;
    wait_ready(5, n);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    send_byte(8'h3C, 1'b0);
    send_byte(8'h3D, 1'b0);
    send_byte(8'h3E, 1'b0);
    send_byte(8'h3F, 1'b1);
    idle_inputs();
    tick();
    tests++;
    if ({bus.buf_in_commit, bus.buf_in_commit_len} !== {1'b1, 10'd4} || write_errs() != 0) begin
      fails++;
      $display("FAIL bp_commit: commit=%b len=%0d write_errs=%0d required 1 4 0",
               bus.buf_in_commit, bus.buf_in_commit_len, write_errs());
    end
    bus.buf_in_commit_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 4 && (bus.busy !== 1'b1 || bus.buf_in_commit !== 1'b0 || bus.in_ready !== 1'b0)) bad++;
    end
    pkts_model++;
    tests++;
    if (bad != 0 || bus.pkt_count !== pkts_model) begin
      fails++;
      $display("FAIL bp_ack_hold: %0d bad cycles, cnt=%0d, required 0 and %0d", bad, bus.pkt_count, pkts_model);
    end
    bus.buf_in_ready      = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_random_stream(input int npkts);
    int n, guard, idle_run, exp_wait;
    logic v, f, acc, closed, dropped, idle;
    logic [7:0] d;
    logic [15:0] cnt;
    for (int p = 0; p < npkts; p++) begin
      clear_mon();
      bus.buf_in_ready = 1'b1;
      wait_ready(8, n);
      closed   = 1'b0;
      guard    = 0;
      idle_run = 0;
      exp_wait = 0;
      while (!closed && guard < 2000) begin
        v = ($urandom_range(0, 9) < 8) || (idle_run >= 40);
        f = ($urandom_range(0, 49) == 0);
        d = 8'($urandom);
        bus.in_valid = v;
        bus.flush    = f;
        bus.in_data  = d;
        acc = v && (bus.in_ready === 1'b1);
        if (acc) begin
          exp_q.push_back(d);
          idle_run = 0;
        end else if (exp_q.size() > 0) begin
          idle_run++;
        end
        if (acc && (exp_q.size() == MAX_LEN || f)) begin
          closed   = 1'b1;
          exp_wait = 1;
        end else if (!acc && f && exp_q.size() > 0) begin
          closed   = 1'b1;
          exp_wait = 0;
        end
        tick();
        guard++;
      end
      idle_inputs();
      tests++;
      if (!closed) begin
        fails++;
        $display("FAIL rnd_stall: packet %0d not closed after %0d cycles", p, guard);
        return;
      end
      n = 0;
      while (bus.buf_in_commit !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      tests++;
      if (bus.buf_in_commit !== 1'b1 || n != exp_wait || bus.buf_in_commit_len !== 10'(exp_q.size())) begin
        fails++;
        $display("FAIL rnd_commit: pkt %0d commit=%b wait=%0d len=%0d required 1 %0d %0d",
                 p, bus.buf_in_commit, n, bus.buf_in_commit_len, exp_wait, exp_q.size());
      end
      tests++;
      if (write_errs() != 0) begin
        fails++;
        $display("FAIL rnd_writes: pkt %0d has %0d write errors (%0d writes, %0d expected)",
                 p, write_errs(), wr_addr.size(), exp_q.size());
      end
      ack_seq(dropped, cnt, idle);
      pkts_model++;
      tests++;
      if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1) begin
        fails++;
        $display("FAIL rnd_ack: pkt %0d dropped=%b cnt=%0d idle=%b required 1 %0d 1", p, dropped, cnt, idle, pkts_model);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    logic dropped, idle;
    logic [15:0] cnt;
    clear_mon();
    bus.buf_in_ready = 1'b1;
    wait_ready(8, n);
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 1'b0);
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.buf_in_wren, bus.buf_in_commit, bus.busy} !== 4'b0 ||
        {bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit_len, bus.pkt_count} !== 43'b0) begin
      fails++;
      $display("FAIL midreset_values: rdy=%b wren=%b commit=%b busy=%b addr=%0h data=%0h len=%0d cnt=%0d required all 0",
               bus.in_ready, bus.buf_in_wren, bus.buf_in_commit, bus.busy,
               bus.buf_in_addr, bus.buf_in_data, bus.buf_in_commit_len, bus.pkt_count);
    end
    repeat (2) tick();
    reset = 1'b0;
    pkts_model = '0;
    clear_mon();
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus.buf_in_commit !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL midreset_no_commit: commit cycles=%0d writes=%0d required 0 0", bad, wr_addr.size());
    end
    wait_ready(8, n);
    send_byte(8'h77, 1'b1);
    idle_inputs();
    tests++;
    if ({bus.buf_in_wren, bus.buf_in_addr, bus.buf_in_data} !== {1'b1, 9'd0, 8'h77}) begin
      fails++;
      $display("FAIL midreset_restart: wren=%b addr=%0d data=%0h required 1 0 77",
               bus.buf_in_wren, bus.buf_in_addr, bus.buf_in_data);
    end
    tick();
    tests++;
    if ({bus.buf_in_commit, bus.buf_in_commit_len} !== {1'b1, 10'd1}) begin
      fails++;
      $display("FAIL midreset_commit: commit=%b len=%0d required 1 1", bus.buf_in_commit, bus.buf_in_commit_len);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (bus.buf_in_commit !== 1'b0 || bus.buf_in_commit_len !== 10'd0) begin
      fails++;
      $display("FAIL async_commit_drop: commit=%b len=%0d required 0 0", bus.buf_in_commit, bus.buf_in_commit_len);
    end
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();
    wait_ready(8, n);
    send_byte(8'h9A, 1'b1);
    idle_inputs();
    tick();
    ack_seq(dropped, cnt, idle);
    pkts_model++;
    tests++;
    if (dropped !== 1'b1 || cnt !== pkts_model || idle !== 1'b1 || write_errs() != 0) begin
      fails++;
      $display("FAIL postreset_pkt: dropped=%b cnt=%0d idle=%b write_errs=%0d required 1 %0d 1 0",
               dropped, cnt, idle, write_errs(), pkts_model);
    end
  endtask

  initial begin
    idle_inputs();
    bus.buf_in_ready      = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    test_reset();
    test_empty_flush();
    test_single_flush();
    test_flush_alone();
    test_full_packet();
    test_timeout();
    test_backpressure();
    test_random_stream(20);
    test_reset_mid();
    tests++;
    if (order_err != 0) begin
      fails++;
      $display("FAIL commit_order: commit overlapped a write %0d times, required 0", order_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_in_packer.md
# usb_in_packer

Packs a byte stream from the compute stage (hamming/ISO search results) into USB IN-endpoint packets for the usb2_top IN buffer interface. It accepts bytes over a valid/ready handshake and writes them to the endpoint buffer. It commits a packet when the packet is full, on an explicit flush, or after an idle timeout, using the buf_in_ready / buf_in_commit / buf_in_commit_ack handshake. It replaces the hand-coded single-byte commit sequence in the top-level state machine.

## Interface
Parameters:
- MAX_LEN, 512, maximum packet length in bytes, 1..512.
- TIMEOUT, 50000, idle cycles with a partial packet before auto-commit; 0 disables the timeout.

Ports:
- clk_50  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset; every register clears on assertion.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- flush  in  1  single-cycle request to commit the current partial packet.
- buf_in_addr  out  9  IN buffer write address.
- buf_in_data  out  8  IN buffer write data.
- buf_in_wren  out  1  IN buffer write strobe, one cycle per byte.
- buf_in_ready  in  1  IN buffer free; asynchronous to clk_50.
- buf_in_commit  out  1  commit request, level.
- buf_in_commit_len  out  10  committed packet length in bytes.
- buf_in_commit_ack  in  1  commit acknowledge; asynchronous to clk_50.
- busy  out  1  high whenever the state is not ST_IDLE.
- pkt_count  out  16  number of committed packets; wraps from 0xFFFF to 0.

## Operation
- buf_in_ready and buf_in_commit_ack each pass through a 2-flop synchronizer before use, giving ready_s and ack_s.
- The byte counter count is 10 bits. in_ready = (state==ST_FILL) & (count<MAX_LEN) & ~commit_pend. in_ready is combinational from registers only.
- ST_IDLE: count=0, in_ready=0. When ready_s=1, go to ST_FILL.
- ST_FILL, on each accepted byte:
  - register buf_in_addr=count[8:0], buf_in_data=in_data and buf_in_wren=1 for the next cycle;
  - count<=count+1;
  - clear the idle timer.
- ST_FILL, commit_pend is set when any of these occurs:
  - count reaches MAX_LEN;
  - flush=1 with count>0, or with a byte accepted in the same cycle;
  - the idle timer reaches TIMEOUT with count>0.
- With commit_pend set, the next cycle goes to ST_COMMIT. buf_in_commit_len is latched from count at that point.
- flush is a no-op when count==0, and a no-op in every state other than ST_FILL. Flush never produces a zero-length packet.
- ST_COMMIT: buf_in_commit=1 and buf_in_commit_len is held. When ack_s=1, drop buf_in_commit, increment pkt_count, and go to ST_WAIT_ACK.
- ST_WAIT_ACK: when ack_s=0, go to ST_IDLE.
- Idle timer: 16 bits, counts only in ST_FILL with count>0 and no accepted byte that cycle. It saturates at TIMEOUT.
- Reset mid-packet: the partial packet is discarded and no commit is issued. buf_in_commit drops asynchronously.

## Timing
- Reset values: in_ready=0, buf_in_addr=0, buf_in_data=0, buf_in_wren=0, buf_in_commit=0, buf_in_commit_len=0, busy=0, pkt_count=0. All registers clear, including the synchronizers.
- Write latency: byte accepted at edge t gives buf_in_wren high during cycle t+1, with addr and data valid in the same cycle.
- Commit ordering: buf_in_commit rises no earlier than the cycle after the last buf_in_wren. The write always completes before the commit.
- A full packet blocks input: the last byte is accepted at t, in_ready=0 from t+1, and buf_in_commit=1 at t+2.
- Flush handling: flush at t with no byte accepted gives buf_in_commit=1 at t+1. Flush at t together with an accepted byte gives buf_in_commit=1 at t+2, with that byte included.
- Synchronizer latency: a buf_in_ready or buf_in_commit_ack edge takes effect 2–3 cycles later.
- Throughput: one byte per cycle while in ST_FILL.

## Test plan
- Single-byte flush: ready=1, then 0x05 with flush in the same cycle. Required: one wren at addr 0 with data 0x05, then commit with len=1. After ack high then low, pkt_count=1 and busy=0.
- Full packet: 512 consecutive bytes 0x00..0xFF repeating, no flush. Required:
  - addr runs 0..511 with matching data;
  - in_ready drops after byte 511;
  - commit len=512;
  - in_ready stays 0 until ready_s reasserts.
- Timeout: TIMEOUT=100, 3 bytes, then in_valid=0. Required: commit len=3 exactly 100 idle cycles after the 3rd byte, ±1 cycle.
- Empty flush: flush pulses in ST_IDLE, and in ST_FILL with count=0. Required: no commit, no wren, pkt_count unchanged.
- Back-pressure: buf_in_ready=0 at start with in_valid held high. Required: in_ready=0 and no wren until ready rises. Ack held high for 20 cycles keeps the block in ST_WAIT_ACK with in_ready=0.
- Reset mid-packet: reset after 10 bytes. Required:
  - all outputs return to their reset values immediately;
  - no commit is issued;
  - the next packet starts at addr 0.
